// File: rtl/nn_pkg.sv
// Shared types and dimensions for the axis_nn 2-3-2 Q4.12 inference engine.
package nn_pkg;
   localparam int DW        = 64;
   localparam int FRAC      = 12;
   localparam int N_HID     = 3;
   localparam int N_OUT     = 2;
   localparam int N_SAMP    = 4;
   localparam int IN_BEATS  = 7;
   localparam int OUT_BEATS = 2;

   typedef logic signed [15:0] q_t;
   typedef logic signed [35:0] acc_t;

   typedef enum logic [1:0] {LOAD, COMPUTE, SEND} state_t;

   // 16-bit lane i of a stream beat, reinterpreted as Q4.12
   function automatic q_t lane(input logic [DW-1:0] d, input int i);
      return q_t'(d[16*i +: 16]);
   endfunction
endpackage

// File: rtl/nn_neuron.sv
// Combinational 3-input Q4.12 neuron: MAC + bias, arithmetic shift, saturation, optional ReLU.
module nn_neuron
   import nn_pkg::*;
(
   input  logic relu_en,
   input  q_t   w0,
   input  q_t   w1,
   input  q_t   w2,
   input  q_t   x0,
   input  q_t   x1,
   input  q_t   x2,
   input  q_t   bias,
   output q_t   y
);
   function automatic q_t sat(input acc_t v);
      if (v > acc_t'(32767))
         return q_t'(16'sh7FFF);
      else if (v < acc_t'(-32768))
         return q_t'(16'sh8000);
      else
         return q_t'(v);
   endfunction

   logic signed [31:0] p0, p1, p2;
   acc_t acc, shifted;
   q_t   s;

   always_comb begin
      p0      = w0 * x0;
      p1      = w1 * x1;
      p2      = w2 * x2;
      acc     = (acc_t'(bias) <<< FRAC) + acc_t'(p0) + acc_t'(p1) + acc_t'(p2);
      shifted = acc >>> FRAC;
      s       = sat(shifted);
      y       = (relu_en && (s < 0)) ? '0 : s;
   end
endmodule

// File: rtl/axis_nn.sv
// AXI4-Stream 2-3-2 Q4.12 network: 7-beat frame in (weights + 4 samples), 2 result beats out.
// Define NN_RELU_EN to apply ReLU on the hidden layer; otherwise the hidden layer is linear.
module axis_nn
   import nn_pkg::*;
(
   input  logic          aclk,
   input  logic          aresetn,
   output logic          s_axis_tready,
   input  logic [DW-1:0] s_axis_tdata,
   input  logic          s_axis_tvalid,
   input  logic          s_axis_tlast,
   input  logic          m_axis_tready,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   output logic          m_axis_tlast
);
`ifdef NN_RELU_EN
   localparam logic RELU = 1'b1;
`else
   localparam logic RELU = 1'b0;
`endif

   state_t     state;
   logic [2:0] beat;
   logic [1:0] samp;
   logic       out_beat;

   q_t hw [N_HID][2];
   q_t hb [N_HID];
   q_t ow [N_OUT][N_HID];
   q_t ob [N_OUT];
   q_t xa [N_SAMP];
   q_t xb [N_SAMP];
   q_t ya [N_SAMP];
   q_t yb [N_SAMP];
   q_t h  [N_HID];
   q_t yo [N_OUT];

   // one sample per clock flows through both layers combinationally
   for (genvar k = 0; k < N_HID; k++) begin : g_hid
      nn_neuron u_hid (
         .relu_en(RELU), .w0(hw[k][0]), .w1(hw[k][1]), .w2('0),
         .x0(xa[samp]), .x1(xb[samp]), .x2('0), .bias(hb[k]), .y(h[k])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      nn_neuron u_out (
         .relu_en(1'b0), .w0(ow[j][0]), .w1(ow[j][1]), .w2(ow[j][2]),
         .x0(h[0]), .x1(h[1]), .x2(h[2]), .bias(ob[j]), .y(yo[j])
      );
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= LOAD;
         beat          <= '0;
         samp          <= '0;
         out_beat      <= 1'b0;
         s_axis_tready <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         for (int k = 0; k < N_HID; k++) begin
            hw[k][0] <= '0;
            hw[k][1] <= '0;
            hb[k]    <= '0;
         end
         for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_HID; k++) ow[j][k] <= '0;
            ob[j] <= '0;
         end
         for (int n = 0; n < N_SAMP; n++) begin
            xa[n] <= '0;
            xb[n] <= '0;
            ya[n] <= '0;
            yb[n] <= '0;
         end
      end else begin
         case (state)
            LOAD: begin
               s_axis_tready <= 1'b1;
               if (s_axis_tvalid && s_axis_tready) begin
                  for (int k = 0; k < N_HID; k++) begin
                     if (beat == 3'(k)) begin
                        hw[k][0] <= lane(s_axis_tdata, 0);
                        hw[k][1] <= lane(s_axis_tdata, 1);
                        hb[k]    <= lane(s_axis_tdata, 2);
                     end
                  end
                  for (int j = 0; j < N_OUT; j++) begin
                     if (beat == 3'(N_HID + j)) begin
                        for (int k = 0; k < N_HID; k++) ow[j][k] <= lane(s_axis_tdata, k);
                        ob[j] <= lane(s_axis_tdata, 3);
                     end
                  end
                  for (int n = 0; n < N_SAMP; n++) begin
                     if (beat == 3'(N_HID + N_OUT))  xa[n] <= lane(s_axis_tdata, n);
                     if (beat == 3'(IN_BEATS - 1))   xb[n] <= lane(s_axis_tdata, n);
                  end
                  // beat 6 always completes the frame; an earlier tlast aborts it
                  if (beat == 3'(IN_BEATS - 1)) begin
                     state         <= COMPUTE;
                     s_axis_tready <= 1'b0;
                     beat          <= '0;
                     samp          <= '0;
                  end else if (s_axis_tlast) begin
                     beat <= '0;
                  end else begin
                     beat <= beat + 3'd1;
                  end
               end
            end
            COMPUTE: begin
               ya[samp] <= yo[0];
               yb[samp] <= yo[1];
               samp     <= samp + 2'd1;
               if (samp == 2'(N_SAMP - 1)) begin
                  state    <= SEND;
                  out_beat <= 1'b0;
               end
            end
            SEND: begin
               if (!m_axis_tvalid) begin
                  m_axis_tdata  <= {ya[3], ya[2], ya[1], ya[0]};
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  out_beat      <= 1'b0;
               end else if (m_axis_tready) begin
                  if (out_beat != 1'(OUT_BEATS - 1)) begin
                     m_axis_tdata <= {yb[3], yb[2], yb[1], yb[0]};
                     m_axis_tlast <= 1'b1;
                     out_beat     <= 1'b1;
                  end else begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     out_beat      <= 1'b0;
                     state         <= LOAD;
                     s_axis_tready <= 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_nn.sv
// Self-checking bench for axis_nn: directed frames plus randomized frames against a layer-level model.
module tb_axis_nn;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;

   int asserts = 0;
   int fails   = 0;

   logic [15:0] hw [3][2];
   logic [15:0] hb [3];
   logic [15:0] ow [2][3];
   logic [15:0] ob [2];
   logic [15:0] xs0 [4];
   logic [15:0] xs1 [4];
   logic [63:0] fr [7];

   always #5 aclk = ~aclk;

   axis_nn dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
   );

   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   // real-valued rule: value = acc / 4096 truncated toward -inf, clamped to 16-bit signed
   function automatic logic [15:0] satq(input longint a);
      longint s;
      s = a >>> 12;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   task automatic model(output logic [63:0] e0, output logic [63:0] e1);
      logic [15:0] h [3];
      logic [15:0] y;
      longint      a;
      e0 = '0;
      e1 = '0;
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 3; k++) begin
            a = sx(hb[k]) * 4096 + sx(hw[k][0]) * sx(xs0[n]) + sx(hw[k][1]) * sx(xs1[n]);
            h[k] = satq(a);
`ifdef NN_RELU_EN
            if ($signed(h[k]) < 0) h[k] = 16'h0000;
`endif
         end
         for (int j = 0; j < 2; j++) begin
            a = sx(ob[j]) * 4096;
            for (int k = 0; k < 3; k++) a = a + sx(ow[j][k]) * sx(h[k]);
            y = satq(a);
            if (j == 0) e0[16*n +: 16] = y;
            else        e1[16*n +: 16] = y;
         end
      end
   endtask

   function automatic logic [15:0] rnd16();
      if ($urandom_range(0, 1) == 1) return 16'($urandom);
      return 16'($urandom_range(0, 16'h3000)) - 16'h1800;
   endfunction

   task automatic randomize_net();
      for (int k = 0; k < 3; k++) begin
         hw[k][0] = rnd16(); hw[k][1] = rnd16(); hb[k] = rnd16();
      end
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < 3; k++) ow[j][k] = rnd16();
         ob[j] = rnd16();
      end
      for (int n = 0; n < 4; n++) begin
         xs0[n] = rnd16(); xs1[n] = rnd16();
      end
   endtask

   task automatic set_identity();
      for (int k = 0; k < 3; k++) begin
         hw[k][0] = 16'h1000; hw[k][1] = 16'h1000; hb[k] = 16'h0000;
      end
      ow[0][0] = 16'h1000; ow[0][1] = 16'h0000; ow[0][2] = 16'h0000; ob[0] = 16'h0000;
      ow[1][0] = 16'h0000; ow[1][1] = 16'h0000; ow[1][2] = 16'h0000; ob[1] = 16'hF000;
      for (int n = 0; n < 4; n++) begin
         xs0[n] = 16'h2000; xs1[n] = 16'h2000;
      end
   endtask

   task automatic build_frame();
      for (int k = 0; k < 3; k++) fr[k] = {16'($urandom), hb[k], hw[k][1], hw[k][0]};
      for (int j = 0; j < 2; j++) fr[3+j] = {ob[j], ow[j][2], ow[j][1], ow[j][0]};
      fr[5] = {xs0[3], xs0[2], xs0[1], xs0[0]};
      fr[6] = {xs1[3], xs1[2], xs1[1], xs1[0]};
   endtask

   task automatic send_beat(input logic [63:0] d, input logic last);
      int n = 0;
      bit ok = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      while (!ok && n < 100) begin
         @(negedge aclk);
         ok = s_axis_tready;
         @(posedge aclk);
         #1;
         n++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      asserts++;
      if (!ok) begin
         fails++;
         $display("FAIL send_timeout: beat %h not accepted in %0d clks", d, n);
      end
   endtask

   task automatic send_frame();
      for (int i = 0; i < 7; i++) send_beat(fr[i], i == 6);
   endtask

   task automatic recv(input bit rnd, output logic [63:0] d0, output logic [63:0] d1,
                       output logic l0, output logic l1);
      int got = 0;
      int n = 0;
      d0 = '0; d1 = '0; l0 = 1'b0; l1 = 1'b0;
      while (got < 2 && n < 300) begin
         @(negedge aclk);
         m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_axis_tvalid && m_axis_tready) begin
            if (got == 0) begin d0 = m_axis_tdata; l0 = m_axis_tlast; end
            else          begin d1 = m_axis_tdata; l1 = m_axis_tlast; end
            got++;
         end
         @(posedge aclk);
         #1;
         n++;
      end
      m_axis_tready = 1'b0;
      asserts++;
      if (got != 2) begin
         fails++;
         $display("FAIL recv_timeout: got %0d beats, required 2", got);
      end
   endtask

   task automatic wait_tvalid();
      int n = 0;
      while (!m_axis_tvalid && n < 50) begin
         @(posedge aclk);
         #1;
         n++;
      end
      asserts++;
      if (!m_axis_tvalid) begin
         fails++;
         $display("FAIL tvalid_timeout: tvalid %b after %0d clks, required 1", m_axis_tvalid, n);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      asserts++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 67'd0) begin
         fails++;
         $display("FAIL reset_outputs: tready=%b tvalid=%b tlast=%b tdata=%h, required all 0",
                  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      asserts++;
      if (s_axis_tready !== 1'b0) begin
         fails++;
         $display("FAIL reset_tready_early: tready=%b, required 0 before first edge", s_axis_tready);
      end
      @(posedge aclk);
      #1;
      asserts++;
      if (s_axis_tready !== 1'b1) begin
         fails++;
         $display("FAIL reset_tready_rise: tready=%b, required 1", s_axis_tready);
      end
   endtask

   task automatic test_identity();
      logic [63:0] d0, d1;
      logic        l0, l1;
      int          lat = 0;
      set_identity();
      build_frame();
      m_axis_tready = 1'b0;
      send_frame();
      while (!m_axis_tvalid && lat < 20) begin
         @(posedge aclk);
         #1;
         lat++;
      end
      asserts++;
      if (lat != 5) begin
         fails++;
         $display("FAIL latency: tvalid after %0d edges, required 5", lat);
      end
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== 64'h4000_4000_4000_4000) begin
         fails++;
         $display("FAIL identity_beat0: got %h, required %h", d0, 64'h4000_4000_4000_4000);
      end
      asserts++;
      if (d1 !== 64'hF000_F000_F000_F000) begin
         fails++;
         $display("FAIL identity_beat1: got %h, required %h", d1, 64'hF000_F000_F000_F000);
      end
      asserts++;
      if ({l0, l1} !== 2'b01) begin
         fails++;
         $display("FAIL identity_tlast: got beat0=%b beat1=%b, required 0/1", l0, l1);
      end
   endtask

   task automatic test_mixed();
      logic [63:0] d0, d1;
      logic        l0, l1;
      set_identity();
      xs0[0] = 16'h1400; xs0[1] = 16'h1400; xs0[2] = 16'h2000; xs0[3] = 16'h2000;
      xs1[0] = 16'h1400; xs1[1] = 16'h2000; xs1[2] = 16'h1400; xs1[3] = 16'h2000;
      build_frame();
      send_frame();
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== 64'h4000_3400_3400_2800) begin
         fails++;
         $display("FAIL mixed_y0: got %h, required %h", d0, 64'h4000_3400_3400_2800);
      end
   endtask

   task automatic test_activation();
      logic [63:0] d0, d1, want;
      logic        l0, l1;
      set_identity();
      for (int k = 0; k < 3; k++) begin
         hw[k][1] = 16'h0000; hb[k] = 16'h8000;
      end
`ifdef NN_RELU_EN
      want = 64'h0;
`else
      want = 64'hA000_A000_A000_A000;
`endif
      build_frame();
      send_frame();
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== want) begin
         fails++;
         $display("FAIL activation_y0: got %h, required %h", d0, want);
      end
   endtask

   task automatic test_saturation();
      logic [63:0] d0, d1;
      logic        l0, l1;
      set_identity();
      for (int k = 0; k < 3; k++) begin
         hw[k][0] = 16'h2000; hw[k][1] = 16'h2000;
      end
      build_frame();
      send_frame();
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== 64'h7FFF_7FFF_7FFF_7FFF) begin
         fails++;
         $display("FAIL saturation_y0: got %h, required %h", d0, 64'h7FFF_7FFF_7FFF_7FFF);
      end
   endtask

   task automatic test_random();
      logic [63:0] d0, d1, e0, e1;
      logic        l0, l1;
      for (int f = 0; f < 8; f++) begin
         randomize_net();
         build_frame();
         model(e0, e1);
         send_frame();
         recv(1'b1, d0, d1, l0, l1);
         asserts++;
         if (d0 !== e0 || d1 !== e1 || {l0, l1} !== 2'b01) begin
            fails++;
            $display("FAIL random_frame%0d: got %h %h last %b%b, required %h %h last 01",
                     f, d0, d1, l0, l1, e0, e1);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] d0, d1, e0, e1, held;
      logic        l0, l1;
      randomize_net();
      build_frame();
      model(e0, e1);
      m_axis_tready = 1'b0;
      send_frame();
      wait_tvalid();
      held = m_axis_tdata;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk);
         #1;
         asserts++;
         if (m_axis_tdata !== held || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0
             || s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold%0d: tdata=%h tvalid=%b tlast=%b s_tready=%b, required %h 1 0 0",
                     i, m_axis_tdata, m_axis_tvalid, m_axis_tlast, s_axis_tready, held);
         end
      end
      s_axis_tvalid = 1'b0;
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== e0 || d1 !== e1) begin
         fails++;
         $display("FAIL backpressure_data: got %h %h, required %h %h", d0, d1, e0, e1);
      end
   endtask

   task automatic test_abort();
      logic [63:0] d0, d1, e0, e1;
      logic        l0, l1;
      bit          seen = 1'b0;
      randomize_net();
      build_frame();
      for (int i = 0; i < 4; i++) send_beat(fr[i], i == 3);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk);
         #1;
         if (m_axis_tvalid) seen = 1'b1;
      end
      m_axis_tready = 1'b0;
      asserts++;
      if (seen || s_axis_tready !== 1'b1) begin
         fails++;
         $display("FAIL abort_no_output: tvalid seen=%b s_tready=%b, required 0 and 1", seen, s_axis_tready);
      end
      randomize_net();
      build_frame();
      model(e0, e1);
      send_frame();
      recv(1'b0, d0, d1, l0, l1);
      asserts++;
      if (d0 !== e0 || d1 !== e1 || {l0, l1} !== 2'b01) begin
         fails++;
         $display("FAIL abort_next_frame: got %h %h last %b%b, required %h %h last 01",
                  d0, d1, l0, l1, e0, e1);
      end
   endtask

   task automatic test_reset_send();
      logic [63:0] d0, d1, e0, e1;
      logic        l0, l1;
      randomize_net();
      build_frame();
      m_axis_tready = 1'b0;
      send_frame();
      wait_tvalid();
      #2;
      aresetn = 1'b0;
      #1;
      asserts++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 67'd0) begin
         fails++;
         $display("FAIL reset_in_send: tready=%b tvalid=%b tlast=%b tdata=%h, required all 0",
                  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      asserts++;
      if (s_axis_tready !== 1'b1) begin
         fails++;
         $display("FAIL reset_send_tready: tready=%b, required 1", s_axis_tready);
      end
      randomize_net();
      build_frame();
      model(e0, e1);
      send_frame();
      recv(1'b1, d0, d1, l0, l1);
      asserts++;
      if (d0 !== e0 || d1 !== e1) begin
         fails++;
         $display("FAIL reset_send_recover: got %h %h, required %h %h", d0, d1, e0, e1);
      end
   endtask

   initial begin
      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;
      test_reset();
      test_identity();
      test_mixed();
      test_activation();
      test_saturation();
      test_random();
      test_backpressure();
      test_abort();
      test_reset_send();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
